// File: rtl/axi_b_resp_gen.sv
// AXI4 write-response generator: pairs AW IDs with W-burst completions into B beats.
// Optional BVALID stall flag enabled by defining AXI_B_RESP_TIMEOUT_EN.
module axi_b_resp_gen #(
    parameter int ID_W           = 4,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic                       S_AWVALID,
    output logic                       S_AWREADY,
    input  logic [ID_W-1:0]            S_AWID,
    input  logic                       S_WVALID,
    input  logic                       S_WREADY,
    input  logic                       S_WLAST,
    input  logic                       wr_err_i,
    output logic                       w_accept_o,
    output logic [ID_W-1:0]            S_BID,
    output logic [1:0]                 S_BRESP,
    output logic                       S_BVALID,
    input  logic                       S_BREADY,
    output logic [$clog2(DEPTH):0]     outstanding_o,
    output logic                       bresp_timeout_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;

    typedef enum logic { IDLE, RESP } state_t;

    state_t          state_q;
    logic [ID_W-1:0] aw_mem [DEPTH];
    logic            w_mem  [DEPTH];
    logic [PW:0]     aw_wr_q, aw_rd_q, w_wr_q, w_rd_q;
    logic [ID_W-1:0] bid_q;
    logic [1:0]      bresp_q;
    logic            bvalid_q;
    logic [OW-1:0]   out_q, out_d;

    logic aw_full, aw_empty, w_full, w_empty;
    logic aw_push, w_push, pop, b_hs;

    // Extra MSB on each pointer distinguishes full from empty.
    assign aw_empty = (aw_wr_q == aw_rd_q);
    assign aw_full  = (aw_wr_q[PW] != aw_rd_q[PW]) &&
                      (aw_wr_q[PW-1:0] == aw_rd_q[PW-1:0]);
    assign w_empty  = (w_wr_q == w_rd_q);
    assign w_full   = (w_wr_q[PW] != w_rd_q[PW]) &&
                      (w_wr_q[PW-1:0] == w_rd_q[PW-1:0]);

    assign S_AWREADY  = !aw_full;
    assign w_accept_o = !w_full;

    assign aw_push = S_AWVALID && !aw_full;
    assign w_push  = S_WVALID && S_WREADY && S_WLAST && !w_full;
    assign b_hs    = bvalid_q && S_BREADY;
    assign pop     = !aw_empty && !w_empty && (!bvalid_q || S_BREADY);

    always_ff @(posedge ACLK) begin
        if (aw_push) aw_mem[aw_wr_q[PW-1:0]] <= S_AWID;
        if (w_push)  w_mem[w_wr_q[PW-1:0]]   <= wr_err_i;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_wr_q <= '0;
            aw_rd_q <= '0;
            w_wr_q  <= '0;
            w_rd_q  <= '0;
        end else begin
            if (aw_push) aw_wr_q <= aw_wr_q + 1'b1;
            if (w_push)  w_wr_q  <= w_wr_q + 1'b1;
            if (pop) begin
                aw_rd_q <= aw_rd_q + 1'b1;
                w_rd_q  <= w_rd_q + 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q  <= IDLE;
            bvalid_q <= 1'b0;
            bid_q    <= '0;
            bresp_q  <= 2'b00;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        state_q  <= RESP;
                        bvalid_q <= 1'b1;
                        bid_q    <= aw_mem[aw_rd_q[PW-1:0]];
                        bresp_q  <= w_mem[w_rd_q[PW-1:0]] ? 2'b10 : 2'b00;
                    end
                end
                RESP: begin
                    if (S_BREADY) begin
                        if (pop) begin
                            bid_q   <= aw_mem[aw_rd_q[PW-1:0]];
                            bresp_q <= w_mem[w_rd_q[PW-1:0]] ? 2'b10 : 2'b00;
                        end else begin
                            state_q  <= IDLE;
                            bvalid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    bvalid_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        out_d = out_q;
        unique case ({aw_push, b_hs})
            2'b10:   out_d = out_q + OW'(1);
            2'b01:   out_d = out_q - OW'(1);
            default: out_d = out_q;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) out_q <= '0;
        else        out_q <= out_d;
    end

    assign S_BID         = bid_q;
    assign S_BRESP       = bresp_q;
    assign S_BVALID      = bvalid_q;
    assign outstanding_o = out_q;

`ifdef AXI_B_RESP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          to_flag_q;

    always_comb begin
        to_cnt_d = '0;
        if (bvalid_q && !S_BREADY)
            to_cnt_d = (to_cnt_q == TMAX) ? to_cnt_q : to_cnt_q + 1'b1;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            to_cnt_q  <= '0;
            to_flag_q <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            if (to_cnt_d == TMAX) to_flag_q <= 1'b1;
        end
    end

    assign bresp_timeout_o = to_flag_q;
`else
    assign bresp_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_axi_b_resp_gen.sv
// Directed scoreboard bench for axi_b_resp_gen.
module tb_axi_b_resp_gen;
    localparam int ID_W = 4;
    localparam int DEPTH = 4;

    logic            ACLK = 1'b0;
    logic            ARESET;
    logic            S_AWVALID;
    logic            S_AWREADY;
    logic [ID_W-1:0] S_AWID;
    logic            S_WVALID;
    logic            S_WREADY;
    logic            S_WLAST;
    logic            wr_err_i;
    logic            w_accept_o;
    logic [ID_W-1:0] S_BID;
    logic [1:0]      S_BRESP;
    logic            S_BVALID;
    logic            S_BREADY;
    logic [2:0]      outstanding_o;
    logic            bresp_timeout_o;

    int n_pass = 0;
    int n_total = 0;
    logic [5:0] sb [$];

    axi_b_resp_gen #(.ID_W(ID_W), .DEPTH(DEPTH), .TIMEOUT_CYCLES(8)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY), .S_AWID(S_AWID),
        .S_WVALID(S_WVALID), .S_WREADY(S_WREADY), .S_WLAST(S_WLAST),
        .wr_err_i(wr_err_i), .w_accept_o(w_accept_o),
        .S_BID(S_BID), .S_BRESP(S_BRESP), .S_BVALID(S_BVALID),
        .S_BREADY(S_BREADY), .outstanding_o(outstanding_o),
        .bresp_timeout_o(bresp_timeout_o)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: every B handshake is matched against the scoreboard head.
    always @(negedge ACLK) begin
        if (!ARESET && S_BVALID && S_BREADY) begin
            if (sb.size() == 0) begin
                chk("b_unexpected", {S_BID, S_BRESP}, -1);
            end else begin
                logic [5:0] e;
                e = sb.pop_front();
                chk("b_id", S_BID, e[5:2]);
                chk("b_resp", S_BRESP, e[1:0]);
            end
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic aw(input logic [3:0] id);
        S_AWVALID = 1'b1;
        S_AWID = id;
        tick();
        S_AWVALID = 1'b0;
    endtask

    task automatic wl(input logic err);
        S_WVALID = 1'b1;
        S_WREADY = 1'b1;
        S_WLAST = 1'b1;
        wr_err_i = err;
        tick();
        S_WVALID = 1'b0;
        S_WREADY = 1'b0;
        S_WLAST = 1'b0;
        wr_err_i = 1'b0;
    endtask

    initial begin
        int exp_to;
        ARESET = 1'b1;
        S_AWVALID = 0; S_AWID = 0;
        S_WVALID = 0; S_WREADY = 0; S_WLAST = 0; wr_err_i = 0;
        S_BREADY = 1'b1;
        tick();
        chk("rst_bvalid", S_BVALID, 0);
        chk("rst_bid", S_BID, 0);
        chk("rst_bresp", S_BRESP, 0);
        chk("rst_awready", S_AWREADY, 1);
        chk("rst_waccept", w_accept_o, 1);
        chk("rst_outst", outstanding_o, 0);
        chk("rst_timeout", bresp_timeout_o, 0);
        ARESET = 1'b0;
        tick();

        // T1: AW first, WLAST later, OKAY
        sb.push_back({4'd3, 2'b00});
        aw(4'd3);
        chk("t1_outst1", outstanding_o, 1);
        tick(); tick();
        wl(1'b0);
        chk("t1_bv_early", S_BVALID, 0);
        tick();
        chk("t1_bvalid", S_BVALID, 1);
        chk("t1_bid", S_BID, 3);
        tick();
        chk("t1_bv_drop", S_BVALID, 0);
        chk("t1_outst0", outstanding_o, 0);

        // T2: WLAST first with error, AW three cycles later
        sb.push_back({4'd7, 2'b10});
        wl(1'b1);
        tick(); tick();
        chk("t2_bv_wait", S_BVALID, 0);
        aw(4'd7);
        chk("t2_bv_early", S_BVALID, 0);
        tick();
        chk("t2_bvalid", S_BVALID, 1);
        chk("t2_bid", S_BID, 7);
        chk("t2_bresp", S_BRESP, 2);
        tick();
        chk("t2_bv_drop", S_BVALID, 0);

        // T3: BREADY stall for 10 cycles, second response queued behind
        S_BREADY = 1'b0;
        sb.push_back({4'd5, 2'b00});
        sb.push_back({4'd6, 2'b10});
        aw(4'd5); aw(4'd6);
        wl(1'b0); wl(1'b1);
        for (int i = 0; i < 10; i++) begin
`ifdef AXI_B_RESP_TIMEOUT_EN
            exp_to = (i >= 8) ? 1 : 0;
`else
            exp_to = 0;
`endif
            chk("t3_bvalid", S_BVALID, 1);
            chk("t3_bid", S_BID, 5);
            chk("t3_bresp", S_BRESP, 0);
            chk("t3_outst", outstanding_o, 2);
            chk("t3_timeout", bresp_timeout_o, exp_to);
            tick();
        end
        S_BREADY = 1'b1;
        tick();
        chk("t3_next_bv", S_BVALID, 1);
        chk("t3_next_bid", S_BID, 6);
        chk("t3_next_bresp", S_BRESP, 2);
        chk("t3_outst1", outstanding_o, 1);
`ifdef AXI_B_RESP_TIMEOUT_EN
        chk("t3_to_sticky", bresp_timeout_o, 1);
`else
        chk("t3_to_off", bresp_timeout_o, 0);
`endif
        tick();
        chk("t3_bv_drop", S_BVALID, 0);
        chk("t3_outst0", outstanding_o, 0);

        // T4: fill AW queue, then drain back-to-back
        ARESET = 1'b1;
        #1;
        ARESET = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t4_awready_open", S_AWREADY, 1);
            aw(4'(i));
        end
        chk("t4_awready_full", S_AWREADY, 0);
        chk("t4_outst4", outstanding_o, 4);
        chk("t4_waccept", w_accept_o, 1);
        for (int i = 0; i < 4; i++) sb.push_back({4'(i), 2'b00});
        wl(1'b0);
        chk("t4_bv0", S_BVALID, 0);
        for (int i = 0; i < 4; i++) begin
            if (i < 3) wl(1'b0);
            else tick();
            chk("t4_bv_run", S_BVALID, 1);
            chk("t4_bid_run", S_BID, i);
        end
        tick();
        chk("t4_bv_end", S_BVALID, 0);
        chk("t4_awready_back", S_AWREADY, 1);
        chk("t4_outst0", outstanding_o, 0);

        // T5: reset while a response is held with two more queued
        S_BREADY = 1'b0;
        aw(4'd1); aw(4'd2); aw(4'd3);
        wl(1'b0); wl(1'b0); wl(1'b0);
        chk("t5_bv_pre", S_BVALID, 1);
        chk("t5_bid_pre", S_BID, 1);
        ARESET = 1'b1;
        #1;
        chk("t5_bv_rst", S_BVALID, 0);
        chk("t5_outst_rst", outstanding_o, 0);
        chk("t5_awready_rst", S_AWREADY, 1);
        tick();
        ARESET = 1'b0;
        S_BREADY = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_no_spurious", S_BVALID, 0);
        end

        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/axi_b_resp_gen.md
Name: axi_b_resp_gen

Overview:
- Slave-side write response generator for the AXI4 interconnect write path.
- Drives the B channel consumed by the master-side write-response handshake tracker.
- Pairs each accepted AW address (its AWID) with each accepted write-data burst completion (WLAST beat plus error flag), then issues one BID/BRESP per burst with AXI-compliant VALID/READY rules.
- Buffers outstanding AW IDs and burst completions independently, so either may arrive first.

Parameters:
- ID_W, 4, width of AWID/BID.
- DEPTH, 4, entries in each of the AW-ID queue and the W-completion queue; power of 2, ≥2.
- TIMEOUT_CYCLES, 256, BVALID-stall cycles before timeout flag (used only with optional feature).

Ports:
- ACLK  in  1  clock, all logic rising-edge.
- ARESET  in  1  asynchronous, active-high reset.
- S_AWVALID  in  1  AW valid from master.
- S_AWREADY  out  1  high when AW-ID queue not full.
- S_AWID  in  ID_W  AW transaction ID.
- S_WVALID  in  1  W valid.
- S_WREADY  in  1  W ready as driven to master (observed only).
- S_WLAST  in  1  last beat of burst.
- wr_err_i  in  1  burst error (decode miss/slave error), sampled on the WLAST handshake.
- w_accept_o  out  1  high when W-completion queue not full; upstream gates WREADY with it on WLAST beats.
- S_BID  out  ID_W  response ID.
- S_BRESP  out  2  response code.
- S_BVALID  out  1  response valid.
- S_BREADY  in  1  response ready from master.
- outstanding_o  out  $clog2(DEPTH)+1  AW IDs accepted but not yet responded.
- bresp_timeout_o  out  1  sticky stall flag (optional feature).

Behaviour:
- Reset (async assert, sync-safe release): both queues empty, S_BVALID=0, S_BID=0, S_BRESP=2'b00, outstanding_o=0, bresp_timeout_o=0, timeout counter=0.
- Reset values:
  - S_AWREADY=1 and w_accept_o=1 after reset, since both queues are empty.
  - Reset mid-burst or mid-response discards all queued entries and drops S_BVALID immediately.
- AW push: on S_AWVALID && S_AWREADY, S_AWID is written to the AW-ID queue.
- W push:
  - On S_WVALID && S_WREADY && S_WLAST, wr_err_i is written to the W-completion queue.
  - Non-last beats are ignored.
- Queue flags:
  - S_AWREADY = !aw_full; w_accept_o = !w_full. Both are registered-flag derived, with no combinational path from inputs.
  - Push while full cannot occur legally. If it occurs (protocol violation), the push is dropped and the queue is unchanged.
- Output register states, IDLE (S_BVALID=0) and RESP (S_BVALID=1):
  - IDLE→RESP: both queues non-empty. Pop one entry from each, load S_BID=id, S_BRESP = err ? 2'b10 (SLVERR) : 2'b00 (OKAY).
  - RESP→RESP: on S_BREADY, if both queues are still non-empty, pop and reload at the same edge. This sustains back-to-back responses, one per cycle.
  - RESP→IDLE: on S_BREADY with either queue empty.
  - RESP with !S_BREADY: S_BID, S_BRESP and S_BVALID are held stable; no pop.
- Latency: when the later of the AW push and W-completion push is sampled at edge t, S_BVALID is high from edge t+1. There is no combinational input→S_BVALID path.
- Ordering: responses are issued strictly in AW acceptance order, with no ID reordering. The W-completion queue matches bursts in arrival order. A WLAST arriving before its AW waits in the queue.
- Simultaneous events:
  - A push and a pop on the same queue in one cycle are both performed; the count is unchanged.
  - Full queue plus same-cycle pop: READY was already low that cycle, so no push occurs. The queue reopens the next cycle.
- outstanding_o:
  - +1 on AW push, −1 on B handshake, unchanged when both occur in the same cycle.
  - Never wraps; max DEPTH+1 (DEPTH queued plus one in the output register).
- Pointer arithmetic: log2(DEPTH)-bit wrap-around plus an extra wrap bit for full/empty detection.

Optional Feature:
- Macro: AXI_B_RESP_TIMEOUT_EN.
- Defined:
  - A counter increments each cycle S_BVALID && !S_BREADY, and clears on a B handshake or when S_BVALID is low.
  - On reaching TIMEOUT_CYCLES, bresp_timeout_o is set and stays 1 until ARESET.
  - The counter saturates and does not wrap.
  - The response itself is unaffected.
- Undefined: no counter logic; bresp_timeout_o is tied to 0.

Test Plan:
- AW id=3 at cycle 2, WLAST err=0 at cycle 5, BREADY=1 → BVALID high cycle 6, BID=3, BRESP=00, one cycle; outstanding_o 1→0.
- WLAST err=1 first, AW id=7 three cycles later → BVALID one cycle after the AW edge, BID=7, BRESP=10.
- BREADY=0 for 10 cycles with a response pending → BID/BRESP/BVALID stable all 10 cycles; the handshake on cycle 11 pops exactly one entry.
- Push 4 AW ids (0,1,2,3) with no WLAST → S_AWREADY=0 after the 4th. Then 4 WLASTs with BREADY=1 → 4 consecutive BVALID cycles, BID 0,1,2,3 in order, AWREADY back to 1.
- ARESET asserted while BVALID=1 with 2 entries queued → BVALID=0 same cycle; queues empty; after release no spurious response occurs.
- With AXI_B_RESP_TIMEOUT_EN, TIMEOUT_CYCLES=8: BREADY held 0 → bresp_timeout_o=1 on the 8th stall cycle, stays 1 after BREADY. Without the macro it stays 0.
